// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scanner with refresh prescaler, frame-atomic
// double buffering, hex decode, leading-zero blanking and a dark cycle between digits.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS       = 4,
    parameter int CLK_DIV          = 50000,
    parameter bit HEX_EN           = 1'b1,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic                      lz_en,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_sync
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0]          cnt_q;
    logic [IDX_W-1:0]          idx_q;
    logic [4*NUM_DIGITS-1:0]   shadow_dig_q, disp_dig_q;
    logic [NUM_DIGITS-1:0]     shadow_dp_q, disp_dp_q;
    logic [NUM_DIGITS-1:0]     anode_q, anode_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic                      frame_sync_q;

    logic                      tick;
    logic                      wrap;
    logic [NUM_DIGITS-1:0]     lz_blank;
    logic                      seen_nonzero;
    logic [3:0]                cur_code;
    logic                      cur_blank;

    function automatic logic [6:0] decode7(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = HEX_EN ? 7'h77 : 7'h00;
            4'hB: s = HEX_EN ? 7'h7C : 7'h00;
            4'hC: s = HEX_EN ? 7'h39 : 7'h00;
            4'hD: s = HEX_EN ? 7'h5E : 7'h00;
            4'hE: s = HEX_EN ? 7'h79 : 7'h00;
            default: s = HEX_EN ? 7'h71 : 7'h00;
        endcase
        return s;
    endfunction

    assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

    // Scan from the most significant digit down; digit 0 is never lz-blanked.
    always_comb begin
        lz_blank     = '0;
        seen_nonzero = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (disp_dig_q[4*i +: 4] != 4'd0) seen_nonzero = 1'b1;
            lz_blank[i] = lz_en && !seen_nonzero;
        end
    end

    assign cur_code  = disp_dig_q[4*idx_q +: 4];
    assign cur_blank = blank_mask[idx_q] | lz_blank[idx_q];

    // Tick cycle forces all outputs dark so the next digit never ghosts the previous one.
    always_comb begin
        anode_d = '0;
        seg_d   = 7'h00;
        dp_d    = 1'b0;
        if (!tick && !cur_blank) begin
            anode_d[idx_q] = 1'b1;
            seg_d          = decode7(cur_code);
            dp_d           = disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            disp_dig_q   <= '0;
            disp_dp_q    <= '0;
            anode_q      <= '0;
            seg_q        <= 7'h00;
            dp_q         <= 1'b0;
            frame_sync_q <= 1'b0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick) idx_q <= wrap ? '0 : idx_q + 1'b1;
            if (load) begin
                shadow_dig_q <= digits_in;
                shadow_dp_q  <= dp_in;
            end
            // Copy uses the pre-edge shadow, so a load on the wrap edge waits a frame.
            if (wrap) begin
                disp_dig_q <= shadow_dig_q;
                disp_dp_q  <= shadow_dp_q;
            end
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_sync_q <= wrap;
        end
    end

    assign anode      = ANODE_ACTIVE_LOW ? ~anode_q : anode_q;
    assign seg        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp         = SEG_ACTIVE_LOW ? ~dp_q : dp_q;
    assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: scan timing, atomic update, lz blanking, hex, mask, polarity.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  blank_mask;
    logic        lz_en;

    logic [3:0] anode_a, anode_h, anode_s;
    logic [6:0] seg_a, seg_h, seg_s;
    logic       dp_a, dp_h, dp_s;
    logic       fs_a, fs_h, fs_s;

    int c      = 0;
    int errors = 0;
    int checks = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_EN(1'b1), .ANODE_ACTIVE_LOW(1'b1),
                     .SEG_ACTIVE_LOW(1'b0)) u_main (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .blank_mask(blank_mask), .lz_en(lz_en), .anode(anode_a), .seg(seg_a), .dp(dp_a),
        .frame_sync(fs_a));

    seg7_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_EN(1'b0), .ANODE_ACTIVE_LOW(1'b1),
                     .SEG_ACTIVE_LOW(1'b0)) u_nohex (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .blank_mask(blank_mask), .lz_en(lz_en), .anode(anode_h), .seg(seg_h), .dp(dp_h),
        .frame_sync(fs_h));

    seg7_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_EN(1'b1), .ANODE_ACTIVE_LOW(1'b1),
                     .SEG_ACTIVE_LOW(1'b1)) u_sal (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .blank_mask(blank_mask), .lz_en(lz_en), .anode(anode_s), .seg(seg_s), .dp(dp_s),
        .frame_sync(fs_s));

    task automatic step();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic step_to(input int t);
        while (c < t) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load_val(input logic [15:0] d, input logic [3:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; digits_in = '0; dp_in = '0; load = 1'b0; blank_mask = '0; lz_en = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_anode", anode_a, 4'hF);
        chk("rst_seg", seg_a, 7'h00);
        chk("rst_dp", dp_a, 1'b0);
        chk("rst_fs", fs_a, 1'b0);
        chk("rst_sal_seg", seg_s, 7'h7F);
        chk("rst_sal_dp", dp_s, 1'b1);

        // Release; cycle 0 is dark, digit 0 lit from cycle 1 with zeroed buffers.
        rst_n = 1'b1; c = 0;
        load_val(16'h1234, 4'h0);
        chk("first_lit_anode", anode_a, 4'b1110);
        chk("first_lit_seg", seg_a, 7'h3F);
        step_to(15); chk("fs_before_wrap", fs_a, 1'b0);
        step_to(16); chk("fs_wrap", fs_a, 1'b1); chk("dark_wrap", anode_a, 4'hF);
        step_to(17); chk("d0_anode", anode_a, 4'b1110); chk("d0_seg", seg_a, 7'h66);
        chk("fs_one_cycle", fs_a, 1'b0); chk("d0_sal_seg", seg_s, 7'h19);
        chk("d0_dp", dp_a, 1'b0);
        step_to(20); chk("dark_slot1", anode_a, 4'hF);
        step_to(21); chk("d1_anode", anode_a, 4'b1101); chk("d1_seg", seg_a, 7'h4F);

        // Mid-frame load must not disturb digits 2 and 3 of the current frame.
        step_to(24);
        load_val(16'h5678, 4'h0);
        chk("d2_anode", anode_a, 4'b1011); chk("d2_old_seg", seg_a, 7'h5B);
        step_to(29); chk("d3_anode", anode_a, 4'b0111); chk("d3_old_seg", seg_a, 7'h06);
        step_to(33); chk("new_d0", seg_a, 7'h7F);
        step_to(37); chk("new_d1", seg_a, 7'h07);
        step_to(41); chk("new_d2", seg_a, 7'h7D);
        step_to(45); chk("new_d3", seg_a, 7'h6D);

        // Load captured on the wrap edge shows only after the following wrap.
        step_to(47);
        load_val(16'hABCD, 4'h0);
        step_to(49); chk("wrap_load_deferred", seg_a, 7'h7F);
        step_to(65); chk("hex_d", seg_a, 7'h5E); chk("nohex_d", seg_h, 7'h00);
        chk("nohex_anode", anode_h, 4'b1110);
        step_to(69); chk("hex_c", seg_a, 7'h39); chk("nohex_c", seg_h, 7'h00);
        step_to(73); chk("hex_b", seg_a, 7'h7C); chk("nohex_b", seg_h, 7'h00);
        step_to(77); chk("hex_a", seg_a, 7'h77); chk("nohex_a", seg_h, 7'h00);

        // Leading-zero blanking, dp suppressed on a blanked digit.
        lz_en = 1'b1;
        load_val(16'h0070, 4'b0110);
        step_to(81); chk("lz_d0_anode", anode_a, 4'b1110); chk("lz_d0_seg", seg_a, 7'h3F);
        step_to(85); chk("lz_d1_anode", anode_a, 4'b1101); chk("lz_d1_seg", seg_a, 7'h07);
        chk("lz_d1_dp", dp_a, 1'b1);
        step_to(89); chk("lz_d2_anode", anode_a, 4'hF); chk("lz_d2_seg", seg_a, 7'h00);
        chk("lz_d2_dp", dp_a, 1'b0);
        step_to(93); chk("lz_d3_anode", anode_a, 4'hF);
        load_val(16'h0000, 4'h0);
        step_to(97); chk("zero_d0_anode", anode_a, 4'b1110); chk("zero_d0_seg", seg_a, 7'h3F);
        step_to(101); chk("zero_d1_anode", anode_a, 4'hF); chk("zero_d1_seg", seg_a, 7'h00);
        step_to(109); chk("zero_d3_anode", anode_a, 4'hF);

        // blank_mask on digit 2 and active-low segment polarity with dp.
        lz_en = 1'b0; blank_mask = 4'b0100;
        load_val(16'h8888, 4'hF);
        step_to(113); chk("m_d0_anode", anode_a, 4'b1110); chk("m_d0_seg", seg_a, 7'h7F);
        chk("m_d0_dp", dp_a, 1'b1); chk("sal_8_seg", seg_s, 7'h00); chk("sal_8_dp", dp_s, 1'b0);
        step_to(117); chk("m_d1_anode", anode_a, 4'b1101);
        step_to(121); chk("m_d2_anode", anode_a, 4'hF); chk("m_d2_seg", seg_a, 7'h00);
        chk("m_d2_dp", dp_a, 1'b0); chk("sal_blank_seg", seg_s, 7'h7F);
        chk("sal_blank_dp", dp_s, 1'b1);
        step_to(125); chk("m_d3_anode", anode_a, 4'b0111); chk("m_d3_dp", dp_a, 1'b1);
        step_to(128);
        for (int i = 0; i < 16; i++) begin
            chk("mask_anode2_dark", anode_a[2], 1'b1);
            step();
        end

        // Exactly one frame_sync per 4*CLK_DIV cycles.
        for (int i = 0; i < 64; i++) begin
            step();
            if (fs_a) pulses++;
        end
        chk("fs_count_64cyc", pulses, 4);

        // Reset mid-slot: outputs go dark without waiting for a clock edge.
        step_to(210);
        rst_n = 1'b0;
        #1;
        chk("midrst_anode", anode_a, 4'hF); chk("midrst_seg", seg_a, 7'h00);
        chk("midrst_dp", dp_a, 1'b0); chk("midrst_sal_seg", seg_s, 7'h7F);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; c = 0;
        chk("post_rst_dark", anode_a, 4'hF);
        step(); chk("post_rst_d0_anode", anode_a, 4'b1110); chk("post_rst_d0_seg", seg_a, 7'h3F);
        chk("post_rst_d0_dp", dp_a, 1'b0);
        step_to(5); chk("post_rst_d1_anode", anode_a, 4'b1101);
        chk("post_rst_d1_seg", seg_a, 7'h3F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
